// File: rtl/sya_pkg.sv
// Shared types and sizing helpers for the systolic-array accumulator controller.
// Pure declarations; no timing or flow control of its own.
package sya_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COMP,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } acc_state_e;

  // Row index width, kept at least 1 bit so a single-row grid still has a legal port.
  function automatic int row_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Cycles needed for the last beat to walk the skew down to the bottom row.
  function automatic int flush_cyc(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/sya_acc_ctrl_if.sv
// Scheduler, PE-grid and output-buffer signals of the accumulator controller.
// master = controller side, slave = environment side.
interface sya_acc_ctrl_if #(
  parameter int NUM_ROW = 16,
  parameter int KW      = 12
) ();
  import sya_pkg::*;

  localparam int RAW = row_aw(NUM_ROW);

  logic               CfgVld;
  logic               CfgRdy;
  logic [KW-1:0]      CfgK;
  logic               InVld;
  logic               InRdy;
  logic [NUM_ROW-1:0] AccClear;
  logic [NUM_ROW-1:0] AccEnable;
  logic               OutVld;
  logic               OutRdy;
  logic [RAW-1:0]     OutRow;
  logic [NUM_ROW-1:0] DrainSel;

  modport master (
    input  CfgVld, CfgK, InVld, OutRdy,
    output CfgRdy, InRdy, AccClear, AccEnable, OutVld, OutRow, DrainSel
  );

  modport slave (
    output CfgVld, CfgK, InVld, OutRdy,
    input  CfgRdy, InRdy, AccClear, AccEnable, OutVld, OutRow, DrainSel
  );

endinterface

// File: rtl/sya_skew_line.sv
// 1-bit delay line; taps[i] is din delayed i+1 cycles, feeding the skewed row enables.
// No backpressure: shifts every cycle.
module sya_skew_line #(
  parameter int DEPTH = 15
) (
  input  logic             Clk,
  input  logic             Rstn,
  input  logic             din,
  output logic [DEPTH-1:0] taps
);

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      taps <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule

// File: rtl/sya_acc_ctrl.sv
// Per-tile accumulator sequencer: clear, K skewed enable beats, flush, one row drained per OutVld&OutRdy.
// Tile latency 2+K+(NUM_ROW-1)+NUM_ROW+1 cycles with no stalls; InVld bubbles and OutRdy low stretch it.
module sya_acc_ctrl
  import sya_pkg::*;
#(
  parameter int NUM_ROW = 16,
  parameter int KW      = 12
) (
  input  logic            Clk,
  input  logic            Rstn,
  sya_acc_ctrl_if.master  bus,
  output logic            Busy,
  output logic            Done
);

  localparam int             RAW        = row_aw(NUM_ROW);
  localparam logic [RAW-1:0] FLUSH_LAST = RAW'(flush_cyc(NUM_ROW) - 1);
  localparam logic [RAW-1:0] ROW_LAST   = RAW'(NUM_ROW - 1);

  acc_state_e     state, state_nxt;
  logic [KW-1:0]  k_reg;
  logic [KW-1:0]  beat_cnt;
  logic [RAW-1:0] flush_cnt;
  logic [RAW-1:0] row_cnt;

  logic cfg_hs, beat, last_beat, flush_end, out_hs, last_row;

  assign cfg_hs    = bus.CfgVld & (state == ST_IDLE);
  assign beat      = bus.InVld & (state == ST_COMP);
  // k_reg >= 1 whenever COMP is reachable, so K-1 cannot wrap.
  assign last_beat = beat & (beat_cnt == k_reg - KW'(1));
  assign flush_end = (state == ST_FLUSH) & (flush_cnt == FLUSH_LAST);
  assign out_hs    = (state == ST_DRAIN) & bus.OutRdy;
  assign last_row  = (row_cnt == ROW_LAST);

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cfg_hs) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = (k_reg != '0) ? ST_COMP : ST_DRAIN;
      ST_COMP:  if (last_beat) state_nxt = (NUM_ROW == 1) ? ST_DRAIN : ST_FLUSH;
      ST_FLUSH: if (flush_end) state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_hs && last_row) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      k_reg     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_cnt   <= '0;
    end else begin
      if (cfg_hs) k_reg <= bus.CfgK;
      beat_cnt  <= (state == ST_COMP)  ? beat_cnt + KW'(beat) : '0;
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + RAW'(1)  : '0;
      // Row index returns to 0 on the final handshake so OutRow reads 0 in DONE.
      if (state != ST_DRAIN) row_cnt <= '0;
      else if (out_hs)       row_cnt <= last_row ? '0 : row_cnt + RAW'(1);
    end
  end

  if (NUM_ROW > 1) begin : g_skew
    logic [NUM_ROW-2:0] taps;
    sya_skew_line #(.DEPTH(NUM_ROW-1)) u_skew (
      .Clk  (Clk),
      .Rstn (Rstn),
      .din  (beat),
      .taps (taps)
    );
    assign bus.AccEnable = {taps, beat};
  end else begin : g_noskew
    assign bus.AccEnable = beat;
  end

  assign bus.CfgRdy   = (state == ST_IDLE);
  assign bus.InRdy    = (state == ST_COMP);
  assign bus.AccClear = {NUM_ROW{state == ST_CLEAR}};
  assign bus.OutVld   = (state == ST_DRAIN);
  assign bus.OutRow   = row_cnt;
  assign bus.DrainSel = (state == ST_DRAIN) ? (NUM_ROW'(1) << row_cnt) : '0;
  assign Busy         = (state != ST_IDLE);
  assign Done         = (state == ST_DONE);

endmodule
